// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: requester count, data width,
// index type and the output-register FSM states.
package rr_mux_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 4;

    typedef logic [1:0]        idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/downstream handshake bundle for rr_mux_arbiter.
// The lock signal exists only when RR_MUX_ARB_LOCK_EN is defined.
interface rr_mux_arbiter_if;
    import rr_mux_arb_pkg::*;

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    data_t            req_d0;
    data_t            req_d1;
    data_t            req_d2;
    data_t            req_d3;
    logic             out_valid;
    logic             out_ready;
    data_t            out_data;
    idx_t             grant_idx;
`ifdef RR_MUX_ARB_LOCK_EN
    logic             lock;

    modport slave (
        input  req_valid, req_d0, req_d1, req_d2, req_d3, out_ready, lock,
        output req_ready, out_valid, out_data, grant_idx
    );
    modport master (
        output req_valid, req_d0, req_d1, req_d2, req_d3, out_ready, lock,
        input  req_ready, out_valid, out_data, grant_idx
    );
`else
    modport slave (
        input  req_valid, req_d0, req_d1, req_d2, req_d3, out_ready,
        output req_ready, out_valid, out_data, grant_idx
    );
    modport master (
        output req_valid, req_d0, req_d1, req_d2, req_d3, out_ready,
        input  req_ready, out_valid, out_data, grant_idx
    );
`endif

endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// 4:1 data multiplexer used by rr_mux_arbiter to select the winning word.
module mux_4_1
    import rr_mux_arb_pkg::*;
(
    input  data_t d0_i,
    input  data_t d1_i,
    input  data_t d2_i,
    input  data_t d3_i,
    input  idx_t  sel_i,
    output data_t y_o
);

    always_comb begin
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over 4 requesters feeding a one-entry output register.
// Define RR_MUX_ARB_LOCK_EN to add a lock input that freezes the priority pointer.
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter idx_t RESET_PTR = 2'd0
) (
    input logic              clk,
    input logic              rst,
    rr_mux_arbiter_if.slave  bus
);

    state_e state_q, state_d;
    idx_t   ptr_q, ptr_d;
    idx_t   grant_q, grant_d;
    data_t  out_data_q, out_data_d;

    idx_t   win_idx;
    idx_t   cand;
    data_t  sel_data;
    logic   any_valid;
    logic   accept;
    logic   lock_c;

`ifdef RR_MUX_ARB_LOCK_EN
    assign lock_c = bus.lock;
`else
    assign lock_c = 1'b0;
`endif

    // Scan from the farthest offset down so the requester nearest ptr wins last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_idx   = ptr_q;
        any_valid = 1'b0;
        cand      = ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr_q + idx_t'(i);
            if (bus.req_valid[cand]) begin
                win_idx   = cand;
                any_valid = 1'b1;
            end
        end
    end

    // The output register can take a word when empty or when it drains this cycle.
    assign accept = !rst && any_valid && (state_q == IDLE || bus.out_ready);

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    mux_4_1 u_mux (
        .d0_i  (bus.req_d0),
        .d1_i  (bus.req_d1),
        .d2_i  (bus.req_d2),
        .d3_i  (bus.req_d3),
        .sel_i (win_idx),
        .y_o   (sel_data)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
        if (accept) begin
            state_d    = HOLD;
            grant_d    = win_idx;
            out_data_d = sel_data;
            ptr_d      = lock_c ? ptr_q : win_idx + 2'd1;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= RESET_PTR;
            grant_q    <= 2'd0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.grant_idx = grant_q;

endmodule
